f_div: RTL and testbench

F_DIV -- requirements
Module: f_div

---
 rtl/f_div_pkg.sv | 22 ++
 rtl/f_div_mant.sv | 60 ++++++
 rtl/f_div.sv | 157 +++++++++++++++
 tb/tb_f_div.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/f_div_pkg.sv
// Shared constants, state encoding and special-operand classes for the f_div divider.
package f_div_pkg;

    localparam int          BIAS        = 127;
    localparam int          EXP_MAX     = 255;
    localparam int          ITER        = 25;
    localparam logic [30:0] INF_PATTERN = {8'hFF, 23'h0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_DIVZ = 2'd1,
        SP_ZERO = 2'd2,
        SP_INF  = 2'd3
    } special_t;

endpackage

// File: rtl/f_div_mant.sv
// Restoring mantissa divider: Q = floor(ma * 2^24 / mb), one quotient bit per step, ITER steps.
// done is high during the step that produces the last bit; state only moves on load or step.
module f_div_mant
    import f_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [24:0] q,
    output logic        done
);

    logic [24:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [23:0] mb_q, mb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ge;
    logic [24:0] rem_sub;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        if (load) begin
            rem_d = {1'b0, ma};
            quo_d = '0;
            mb_d  = mb;
            cnt_d = '0;
        end else if (step) begin
            // rem_sub < mb < 2^24, so the shift never loses a bit
            rem_d = {rem_sub[23:0], 1'b0};
            quo_d = {quo_q[23:0], ge};
            cnt_d = cnt_q + 5'd1;
        end
        done = step && !load && (cnt_q == 5'(ITER - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            mb_q  <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            mb_q  <= mb_d;
            cnt_q <= cnt_d;
        end
    end

    assign q = quo_q;

endmodule

// File: rtl/f_div.sv
// IEEE-754 single-precision divider (truncating, no denormals): 26 cycles normal, 1 cycle special.
// START is only taken in IDLE with EN high; EN low freezes every register.
module f_div
    import f_div_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        START,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] OUT_DIV,
    output logic        BUSY,
    output logic        DONE,
    output logic        DIV_ZERO,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam logic signed [9:0] BIAS_E = 10'(BIAS);
    localparam logic signed [9:0] EMAX_E = 10'(EXP_MAX);

    state_t             state_q, state_d;
    special_t           special_q, special_d, special_in;
    logic               sign_q, sign_d;
    logic signed [9:0]  ea_q, ea_d, eb_q, eb_d;
    logic [31:0]        out_div_q, out_div_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               mant_load, mant_step, mant_done;
    logic [24:0]        quo;
    logic signed [9:0]  exp_w;
    logic [22:0]        frac_w;

    f_div_mant u_mant (
        .clk   (CLK),
        .rst_n (RST),
        .load  (mant_load & EN),
        .step  (mant_step & EN),
        .ma    ({1'b1, A[22:0]}),
        .mb    ({1'b1, B[22:0]}),
        .q     (quo),
        .done  (mant_done)
    );

    always_comb begin
        state_d     = state_q;
        special_d   = special_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        out_div_d   = out_div_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mant_load   = 1'b0;
        mant_step   = 1'b0;

        if (B[30:23] == 8'h00)      special_in = SP_DIVZ;
        else if (A[30:23] == 8'h00) special_in = SP_ZERO;
        else if (A[30:23] == 8'hFF) special_in = SP_INF;
        else                        special_in = SP_NONE;

        // Quotient lies in (0.5, 2): bit 24 tells which side of 1.0 it fell on
        exp_w  = ea_q - eb_q + (quo[24] ? BIAS_E : (BIAS_E - 10'sd1));
        frac_w = quo[24] ? quo[23:1] : quo[22:0];

        case (state_q)
            IDLE: begin
                if (START) begin
                    sign_d    = A[31] ^ B[31];
                    ea_d      = {2'b00, A[30:23]};
                    eb_d      = {2'b00, B[30:23]};
                    special_d = special_in;
                    if (special_in == SP_NONE) begin
                        mant_load = 1'b1;
                        state_d   = CALC;
                    end else begin
                        state_d   = NORM;
                    end
                end
            end
            CALC: begin
                mant_step = 1'b1;
                if (mant_done) state_d = NORM;
            end
            NORM: begin
                done_d      = 1'b1;
                div_zero_d  = 1'b0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                state_d     = IDLE;
                case (special_q)
                    SP_DIVZ: begin
                        out_div_d  = {sign_q, INF_PATTERN};
                        div_zero_d = 1'b1;
                    end
                    SP_ZERO: out_div_d = {sign_q, 31'h0};
                    SP_INF: begin
                        out_div_d  = {sign_q, INF_PATTERN};
                        overflow_d = 1'b1;
                    end
                    default: begin
                        if (exp_w >= EMAX_E) begin
                            out_div_d  = {sign_q, INF_PATTERN};
                            overflow_d = 1'b1;
                        end else if (exp_w <= 10'sd0) begin
                            out_div_d   = {sign_q, 31'h0};
                            underflow_d = 1'b1;
                        end else begin
                            out_div_d = {sign_q, exp_w[7:0], frac_w};
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            special_q   <= SP_NONE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            out_div_q   <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (EN) begin
            state_q     <= state_d;
            special_q   <= special_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            out_div_q   <= out_div_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OUT_DIV   = out_div_q;
    assign DONE      = done_q;
    assign DIV_ZERO  = div_zero_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
    assign BUSY      = (state_q == CALC) || (state_q == NORM);

endmodule

// File: tb/tb_f_div.sv
// Directed self-checking bench for f_div: results, flags, latency, reset, EN stall and START-while-BUSY.
module tb_f_div;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b1;
    logic        START = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] OUT_DIV;
    logic        BUSY, DONE, DIV_ZERO, OVERFLOW, UNDERFLOW;

    int checks = 0;
    int failures = 0;

    f_div dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .START     (START),
        .A         (A),
        .B         (B),
        .OUT_DIV   (OUT_DIV),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIV_ZERO  (DIV_ZERO),
        .OVERFLOW  (OVERFLOW),
        .UNDERFLOW (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // Hand-computed vectors; flags are {DIV_ZERO, OVERFLOW, UNDERFLOW}
    localparam int NV = 10;
    logic [31:0] v_a   [NV] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000, 32'h3F800000, 32'h40C00000,
                                32'h7F000000, 32'h00800000, 32'h00000000, 32'hFF800000, 32'h80000000};
    logic [31:0] v_b   [NV] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h40000000,
                                32'h3E800000, 32'h7F000000, 32'h40000000, 32'h40000000, 32'h00000000};
    logic [31:0] v_q   [NV] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h40400000,
                                32'h7F800000, 32'h00000000, 32'h00000000, 32'hFF800000, 32'hFF800000};
    logic [2:0]  v_f   [NV] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                                3'b010, 3'b001, 3'b000, 3'b010, 3'b100};
    int          v_lat [NV] = '{26, 26, 26, 1, 26, 26, 26, 1, 1, 1};

    // Caller is at posedge+1 with the DUT idle (or DONE high); lat=-1 means DONE never came
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0, output logic busy_end);
        START = 1'b1; A = a; B = b;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; B = $urandom;
        busy0 = BUSY;
        lat = -1;
        busy_end = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = i;
                busy_end = BUSY;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; EN = 1'b1; START = 1'b0;
        #12;
        checks++;
        if (OUT_DIV !== 32'h0) begin
            failures++; $display("FAIL reset_out: got %h want 00000000", OUT_DIV);
        end
        checks++;
        if ({DONE, BUSY, DIV_ZERO, OVERFLOW, UNDERFLOW} !== 5'b0) begin
            failures++; $display("FAIL reset_ctl: got %b want 00000", {DONE, BUSY, DIV_ZERO, OVERFLOW, UNDERFLOW});
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_vectors();
        int lat; logic b0, be;
        for (int k = 0; k < NV; k++) begin
            do_div(v_a[k], v_b[k], lat, b0, be);
            checks++;
            if (OUT_DIV !== v_q[k]) begin
                failures++; $display("FAIL vec%0d_out: got %h want %h", k, OUT_DIV, v_q[k]);
            end
            checks++;
            if ({DIV_ZERO, OVERFLOW, UNDERFLOW} !== v_f[k]) begin
                failures++; $display("FAIL vec%0d_flags: got %b want %b", k, {DIV_ZERO, OVERFLOW, UNDERFLOW}, v_f[k]);
            end
            checks++;
            if (lat != v_lat[k]) begin
                failures++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, v_lat[k]);
            end
            checks++;
            if ({b0, be} !== 2'b10) begin
                failures++; $display("FAIL vec%0d_busy: got start=%b end=%b want 1/0", k, b0, be);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic b0, be;
        do_div(32'h40C00000, 32'h40000000, lat, b0, be);
        do_div(32'h3F800000, 32'h40400000, lat, b0, be);
        checks++;
        if (OUT_DIV !== 32'h3EAAAAAA || lat != 26) begin
            failures++; $display("FAIL b2b: got %h lat %0d want 3eaaaaaa lat 26", OUT_DIV, lat);
        end
    endtask

    task automatic test_busy_start();
        int lat = -1;
        int extra = 0;
        START = 1'b1; A = 32'h3F800000; B = 32'h40400000;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 5) begin START = 1'b1; A = 32'h40C00000; B = 32'h40000000; end
            if (i == 6) START = 1'b0;
            @(posedge CLK); #1;
            if (DONE) begin lat = i; break; end
        end
        START = 1'b0;
        checks++;
        if (OUT_DIV !== 32'h3EAAAAAA || lat != 26) begin
            failures++; $display("FAIL busy_start: got %h lat %0d want 3eaaaaaa lat 26", OUT_DIV, lat);
        end
        repeat (30) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL busy_start_ghost: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_enable();
        int lat = -1;
        logic stalled_ok;
        START = 1'b1; A = 32'h40C00000; B = 32'h40000000;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1 EN = 1'b0;
        repeat (5) @(posedge CLK);
        #1 stalled_ok = BUSY && !DONE;
        EN = 1'b1;
        for (int i = 9; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin lat = i; break; end
        end
        checks++;
        if (!stalled_ok) begin
            failures++; $display("FAIL en_hold: got busy=%b done=%b want busy=1 done=0", BUSY, DONE);
        end
        checks++;
        if (OUT_DIV !== 32'h40400000 || lat != 31) begin
            failures++; $display("FAIL en_stall: got %h lat %0d want 40400000 lat 31", OUT_DIV, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic b0, be;
        int ghost = 0;
        do_div(32'h80000000, 32'h00000000, lat, b0, be);
        START = 1'b1; A = 32'h40C00000; B = 32'h40000000;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++;
        if (OUT_DIV !== 32'h0) begin
            failures++; $display("FAIL midreset_out: got %h want 00000000", OUT_DIV);
        end
        checks++;
        if ({DONE, BUSY, DIV_ZERO, OVERFLOW, UNDERFLOW} !== 5'b0) begin
            failures++; $display("FAIL midreset_ctl: got %b want 00000", {DONE, BUSY, DIV_ZERO, OVERFLOW, UNDERFLOW});
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (30) begin
            @(posedge CLK); #1;
            if (DONE || BUSY || OUT_DIV !== 32'h0) ghost++;
        end
        checks++;
        if (ghost != 0) begin
            failures++; $display("FAIL midreset_partial: got %0d active cycles want 0", ghost);
        end
        do_div(32'h40C00000, 32'h40000000, lat, b0, be);
        checks++;
        if (OUT_DIV !== 32'h40400000 || lat != 26) begin
            failures++; $display("FAIL midreset_restart: got %h lat %0d want 40400000 lat 26", OUT_DIV, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_busy_start();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
